// File: rtl/vdp18_pkg.sv
// Shared definitions for the VDP18 video back end.
// Holds the scan doubler defaults and the pixel word stored in its line buffer.
package vdp18_pkg;

  localparam int SCANDBL_ADDR_W    = 9;   // 512 entries per line bank
  localparam int SCANDBL_HSYNC_LEN = 40;  // output hsync width, in 10.7 MHz enables

  // One captured pixel. The colour bit order follows the VDP core (bit 0 = MSB).
  typedef struct packed {
    logic       blank_n;
    logic [0:3] col;
  } scandbl_pix_t;

endpackage

// File: rtl/vdp18_line_ram.sv
// Double-banked line buffer for the scan doubler.
// Simple dual-port RAM with registered read; the address MSB selects the bank.
// Ports:
//   clk_i    system clock
//   we_i     write strobe
//   waddr_i  write address {bank, entry}
//   wdata_i  write data
//   re_i     read strobe (output register updates only when set)
//   raddr_i  read address {bank, entry}
//   rdata_o  registered read data, one re_i later
module vdp18_line_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 5
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W:0]   waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W:0]   raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**(ADDR_W+1)];

  // No reset on storage or output register so this maps onto block RAM.
  // A same-address read and write return the old contents.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/vdp18_scandbl.sv
// Line-doubling scan converter for the VDP18 video outputs.
// Captures each 15.7 kHz input line at the 5.37 MHz pixel rate into one bank of
// the line buffer while the other bank is replayed twice at 10.7 MHz.
// Ports:
//   clk_i          system clock
//   reset_i        synchronous active-high reset
//   clk_en_10m7_i  10.7 MHz clock enable; all state advances only on it
//   enable_i       1 = line doubling, 0 = bypass (sampled at input line start)
//   col_i          colour index in
//   hsync_n_i      hsync in, active low
//   vsync_n_i      vsync in, active low
//   blank_n_i      blank in, active low
//   col_o          colour index out
//   hsync_n_o      hsync out, active low
//   vsync_n_o      vsync out, active low
//   blank_n_o      blank out, active low
//   line_len_o     last measured input line length, in pixels
module vdp18_scandbl
  import vdp18_pkg::*;
#(
  parameter int ADDR_W    = SCANDBL_ADDR_W,
  parameter int HSYNC_LEN = SCANDBL_HSYNC_LEN
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clk_en_10m7_i,
  input  logic              enable_i,
  input  logic [3:0]        col_i,
  input  logic              hsync_n_i,
  input  logic              vsync_n_i,
  input  logic              blank_n_i,
  output logic [3:0]        col_o,
  output logic              hsync_n_o,
  output logic              vsync_n_o,
  output logic              blank_n_o,
  output logic [ADDR_W-1:0] line_len_o
);

  localparam int                PIX_W  = $bits(scandbl_pix_t);
  localparam logic [ADDR_W-1:0] HS_END = ADDR_W'(HSYNC_LEN);

  logic              phase_q, hs_prev_q, bank_q, dbl_q;
  logic              vs_cap_q, vs_out_q, lv_dly_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, rd_dly_q;
  logic [ADDR_W-1:0] line_len_q;
  logic [3:0]        byp_col_q;
  logic              byp_hs_q, byp_vs_q, byp_bl_q;

  logic              strobe, line_start, wr_sat, rd_wrap, we;
  logic [ADDR_W:0]   waddr, raddr;
  scandbl_pix_t      wr_pix, rd_pix;
  logic [PIX_W-1:0]  rdata;

  assign strobe     = clk_en_10m7_i & phase_q;
  assign line_start = strobe & hs_prev_q & ~hsync_n_i;
  assign wr_sat     = &wr_addr_q;
  // With line_len 0 this compares against all-ones, so the read counter just
  // free-runs until the first line has been measured.
  assign rd_wrap    = (rd_addr_q == line_len_q - 1'b1);

  // The pixel that carries the hsync fall is entry 0 of the new line, so it
  // goes to the freshly selected bank; this makes line_len count every pixel
  // from one hsync fall up to (not including) the next.
  assign wr_pix.blank_n = blank_n_i;
  assign wr_pix.col     = col_i;
  assign we    = strobe & (line_start | ~wr_sat);
  assign waddr = line_start ? {~bank_q, {ADDR_W{1'b0}}} : {bank_q, wr_addr_q};
  assign raddr = {~bank_q, rd_addr_q};

  vdp18_line_ram #(.ADDR_W(ADDR_W), .DATA_W(PIX_W)) u_ram (
    .clk_i   (clk_i),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wr_pix),
    .re_i    (clk_en_10m7_i),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  assign rd_pix = rdata;

  always_comb begin
    rd_addr_d = rd_addr_q + 1'b1;
    if (line_start || rd_wrap) rd_addr_d = '0;
    wr_addr_d = wr_addr_q;
    if (line_start)             wr_addr_d = ADDR_W'(1);
    else if (strobe && !wr_sat) wr_addr_d = wr_addr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      phase_q    <= 1'b0;
      hs_prev_q  <= 1'b1;
      bank_q     <= 1'b0;
      dbl_q      <= 1'b1;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      rd_dly_q   <= '0;
      line_len_q <= '0;
      vs_cap_q   <= 1'b1;
      vs_out_q   <= 1'b1;
      lv_dly_q   <= 1'b0;
      byp_col_q  <= '0;
      byp_hs_q   <= 1'b1;
      byp_vs_q   <= 1'b1;
      byp_bl_q   <= 1'b0;
    end else if (clk_en_10m7_i) begin
      phase_q   <= ~phase_q;
      rd_addr_q <= rd_addr_d;
      // Delayed copies line up with the registered RAM output.
      rd_dly_q  <= rd_addr_q;
      lv_dly_q  <= (line_len_q != '0);
      if (rd_addr_q == '0) vs_out_q <= vs_cap_q;
      if (phase_q) begin
        hs_prev_q <= hsync_n_i;
        wr_addr_q <= wr_addr_d;
        byp_col_q <= col_i;
        byp_hs_q  <= hsync_n_i;
        byp_vs_q  <= vsync_n_i;
        byp_bl_q  <= blank_n_i;
        if (line_start) begin
          line_len_q <= wr_addr_q;
          bank_q     <= ~bank_q;
          vs_cap_q   <= vsync_n_i;
          // Mode only changes on a line boundary so no line is torn.
          dbl_q      <= enable_i;
        end
      end
    end
  end

  always_comb begin
    col_o     = byp_col_q;
    hsync_n_o = byp_hs_q;
    vsync_n_o = byp_vs_q;
    blank_n_o = byp_bl_q;
    if (dbl_q) begin
      blank_n_o = lv_dly_q & rd_pix.blank_n;
      col_o     = blank_n_o ? rd_pix.col : 4'd0;
      hsync_n_o = ~(lv_dly_q & (rd_dly_q < HS_END));
      vsync_n_o = vs_out_q;
    end
  end

  assign line_len_o = line_len_q;

endmodule

// File: tb/tb_vdp18_scandbl.sv
module tb_vdp18_scandbl;

  localparam int MAXL = 511;  // most pixels a line can hold

  logic       clk_i = 1'b0, reset_i = 1'b1, clk_en = 1'b0, enable = 1'b1;
  logic [3:0] col = 4'd0;
  logic       hs = 1'b1, vs = 1'b1, bl = 1'b0;
  logic [3:0] col_o;
  logic       hsync_n_o, vsync_n_o, blank_n_o;
  logic [8:0] line_len_o;

  int tests = 0, fails = 0;
  bit chk_on = 0, en_seen = 0, d_ph = 0;
  int hs_low_cnt = 0, c15_cnt = 0;

  vdp18_scandbl dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .clk_en_10m7_i (clk_en),
    .enable_i      (enable),
    .col_i         (col),
    .hsync_n_i     (hs),
    .vsync_n_i     (vs),
    .blank_n_i     (bl),
    .col_o         (col_o),
    .hsync_n_o     (hsync_n_o),
    .vsync_n_o     (vsync_n_o),
    .blank_n_o     (blank_n_o),
    .line_len_o    (line_len_o)
  );

  initial forever #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a captured line is a list of pixels; the displayed line
  // is replayed from a pointer that restarts at each input hsync fall and
  // wraps at the line length. Each output pixel appears one enable after it
  // is addressed.
  bit         m_ph, m_hsp, m_dbl, m_vscap, m_vsout, m_valid;
  logic [4:0] cap[$];
  logic [4:0] disp [512];
  logic [4:0] m_pix;
  int         m_L, m_r, m_idx;
  logic [3:0] b_col, e_col;
  bit         b_hs, b_vs, b_bl, e_hs, e_vs, e_bl;
  int         e_len;

  initial forever begin : model
    bit st, ls;
    @(posedge clk_i);
    en_seen = 0;
    if (reset_i) begin
      m_ph = 0; m_hsp = 1; m_dbl = 1; m_vscap = 1; m_vsout = 1; m_valid = 0;
      cap.delete(); m_L = 0; m_r = 0; m_idx = 0;
      b_col = 0; b_hs = 1; b_vs = 1; b_bl = 0;
    end else if (clk_en) begin
      en_seen = 1;
      st = m_ph;
      m_ph = ~m_ph;
      ls = st && m_hsp && !hs;
      m_valid = (m_L != 0);
      m_idx = m_r;
      m_pix = disp[m_r];
      if (m_r == 0) m_vsout = m_vscap;
      if (ls) m_r = 0;
      else if (m_L != 0 && m_r == m_L - 1) m_r = 0;
      else m_r = (m_r + 1) % 512;
      if (st) begin
        if (ls) begin
          for (int i = 0; i < cap.size(); i++) disp[i] = cap[i];
          m_L = cap.size();
          m_vscap = vs;
          m_dbl = enable;
          cap.delete();
          cap.push_back({bl, col});
        end else if (cap.size() < MAXL) begin
          cap.push_back({bl, col});
        end
        m_hsp = hs;
        b_col = col; b_hs = hs; b_vs = vs; b_bl = bl;
      end
    end
    if (m_dbl) begin
      e_bl  = m_valid && m_pix[4];
      e_col = e_bl ? m_pix[3:0] : 4'd0;
      e_hs  = !(m_valid && m_idx < 40);
      e_vs  = m_vsout;
    end else begin
      e_bl = b_bl; e_col = b_col; e_hs = b_hs; e_vs = b_vs;
    end
    e_len = m_L;
  end

  initial forever begin : compare
    @(negedge clk_i);
    if (chk_on) begin
      check("col_o",      32'(col_o),      32'(e_col));
      check("blank_n_o",  32'(blank_n_o),  32'(e_bl));
      check("hsync_n_o",  32'(hsync_n_o),  32'(e_hs));
      check("vsync_n_o",  32'(vsync_n_o),  32'(e_vs));
      check("line_len_o", 32'(line_len_o), 32'(e_len));
      if (en_seen && hsync_n_o == 1'b0) hs_low_cnt++;
      if (en_seen && col_o == 4'd15) c15_cnt++;
    end
  end

  task automatic en_tick();
    repeat ($urandom_range(0, 1)) begin @(negedge clk_i); clk_en = 1'b0; end
    @(negedge clk_i); clk_en = 1'b1;
    @(posedge clk_i); #1;
    d_ph = ~d_ph;
  endtask

  // Hold one pixel on the inputs until a sample strobe has taken it.
  task automatic pix(input logic [3:0] c, input logic h, input logic v, input logic b);
    bit was;
    col = c; hs = h; vs = v; bl = b;
    do begin was = d_ph; en_tick(); end while (!was);
  endtask

  // kind 0: blank-free ramp k%16; otherwise random colour and blanking.
  task automatic line(input int n, input int hl, input logic v, input int kind);
    for (int k = 0; k < n; k++) begin
      logic [3:0] c;
      logic       b;
      if (kind == 0) begin c = 4'(k % 16); b = 1'b1; end
      else begin c = 4'($urandom); b = ($urandom_range(0, 7) != 0); end
      pix(c, !(k < hl), v, b);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    reset_i = 1'b1; clk_en = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_blank_n", 32'(blank_n_o),  32'd0);
    check("rst_hsync_n", 32'(hsync_n_o),  32'd1);
    check("rst_vsync_n", 32'(vsync_n_o),  32'd1);
    check("rst_col",     32'(col_o),      32'd0);
    check("rst_linelen", 32'(line_len_o), 32'd0);
    reset_i = 1'b0;
    d_ph = 0;
  endtask

  initial begin
    chk_on = 0;
    repeat (3) @(negedge clk_i);
    chk_on = 1;
    do_reset();

    // Line measurement and doubling
    repeat (3) line(342, 26, 1'b1, 0);
    check("line_len_342", 32'(line_len_o), 32'd342);
    hs_low_cnt = 0; c15_cnt = 0;
    line(342, 26, 1'b1, 0);
    check("hs_low_two_replays", 32'(hs_low_cnt), 32'd80);
    check("ramp_col15_count",   32'(c15_cnt),    32'd42);

    // Overflow and recovery
    line(600, 26, 1'b1, 1);
    line(342, 26, 1'b1, 1);
    check("line_len_sat", 32'(line_len_o), 32'd511);
    line(342, 26, 1'b1, 1);
    check("line_len_after_sat", 32'(line_len_o), 32'd342);

    // Vsync: three low input lines
    repeat (3) line(342, 26, 1'b0, 1);
    repeat (3) line(342, 26, 1'b1, 1);

    // Reset in the middle of a line
    line(100, 26, 1'b1, 1);
    do_reset();

    // Random lengths, content and mode
    for (int i = 0; i < 8; i++) begin
      enable = ($urandom_range(0, 2) != 0);
      line($urandom_range(200, 400), 26, ($urandom_range(0, 3) != 0), 1);
    end
    enable = 1'b1;
    line(342, 26, 1'b1, 1);
    line(342, 26, 1'b1, 1);

    // Bypass: takes effect at the hsync fall, outputs follow one strobe later
    enable = 1'b0;
    pix(4'd5, 1'b0, 1'b1, 1'b1);
    check("bypass_col5", 32'(col_o), 32'd5);
    repeat (25) pix(4'd9, 1'b0, 1'b1, 1'b1);
    enable = 1'b1;
    pix(4'd7, 1'b1, 1'b1, 1'b1);
    check("bypass_held_midline", 32'(col_o), 32'd7);
    repeat (3) pix(4'd7, 1'b1, 1'b1, 1'b1);
    pix(4'd3, 1'b0, 1'b1, 1'b1);
    check("bypass_line_len", 32'(line_len_o), 32'd30);
    pix(4'd12, 1'b0, 1'b1, 1'b1);
    check("doubling_resumed", 32'(col_o), 32'd9);
    line(342, 26, 1'b1, 1);

    @(negedge clk_i); clk_en = 1'b0;
    repeat (4) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
